// File: rtl/gfx_pkg.sv
// gfx_pkg: adapter register map, character codes and FSM state types for the console writer
package gfx_pkg;
    localparam logic [3:0] REG_MODE   = 4'd0;
    localparam logic [3:0] REG_DATA   = 4'd1;
    localparam logic [3:0] REG_ADDR_X = 4'd3;
    localparam logic [3:0] REG_ADDR_Y = 4'd4;
    localparam logic [7:0] MODE_MTXT  = 8'h00;
    localparam logic [7:0] CH_BS      = 8'h08;
    localparam logic [7:0] CH_LF      = 8'h0A;
    localparam logic [7:0] CH_FF      = 8'h0C;
    localparam logic [7:0] CH_CR      = 8'h0D;
    localparam logic [7:0] CH_SPACE   = 8'h20;
    localparam logic [7:0] CH_DEL     = 8'h7F;
    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_SET_X, ST_SET_Y, ST_SET_CH, ST_CLEAR} state_e;
    typedef enum logic [1:0] {BUS_IDLE, BUS_SETUP, BUS_HIGH, BUS_HOLD} bus_state_e;
    function automatic logic printable(input logic [7:0] b);
        return b >= CH_SPACE && b != CH_DEL;
    endfunction
endpackage

// File: rtl/gfx_bus_cycle.sv
// gfx_bus_cycle: sequences one adapter write cycle (setup, strobe high, hold) with registered pins
module gfx_bus_cycle
    import gfx_pkg::*;
#(
    parameter int STROBE_HI = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [3:0] rs_i,
    input  logic [7:0] data_i,
    output logic       done_o,
    output logic       bus_cs_n_o,
    output logic [3:0] bus_rs_o,
    output logic       bus_wren_n_o,
    output logic [7:0] bus_data_o,
    output logic       bus_data_oe_o,
    output logic       bus_strobe_o
);
    localparam int CW = STROBE_HI > 1 ? $clog2(STROBE_HI) : 1;
    bus_state_e    st_q;
    logic [CW-1:0] cnt_q;
    assign done_o = st_q == BUS_HOLD;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q          <= BUS_IDLE;
            cnt_q         <= '0;
            bus_cs_n_o    <= 1'b1;
            bus_wren_n_o  <= 1'b1;
            bus_data_oe_o <= 1'b0;
            bus_strobe_o  <= 1'b0;
            bus_rs_o      <= '0;
            bus_data_o    <= '0;
        end else begin
            case (st_q)
                BUS_IDLE: if (start_i) begin
                    st_q          <= BUS_SETUP;
                    bus_cs_n_o    <= 1'b0;
                    bus_wren_n_o  <= 1'b0;
                    bus_data_oe_o <= 1'b1;
                    bus_rs_o      <= rs_i;
                    bus_data_o    <= data_i;
                end
                BUS_SETUP: begin
                    st_q         <= BUS_HIGH;
                    bus_strobe_o <= 1'b1;
                    cnt_q        <= '0;
                end
                BUS_HIGH: if (cnt_q == CW'(STROBE_HI - 1)) begin
                    st_q         <= BUS_HOLD;
                    bus_strobe_o <= 1'b0;
                end else cnt_q <= cnt_q + 1'b1;
                BUS_HOLD: begin
                    st_q          <= BUS_IDLE;
                    bus_cs_n_o    <= 1'b1;
                    bus_wren_n_o  <= 1'b1;
                    bus_data_oe_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/gfx_console_writer.sv
// gfx_console_writer: turns a byte stream into mono-text adapter writes while tracking a cursor
module gfx_console_writer
    import gfx_pkg::*;
#(
    parameter int COLS      = 80,
    parameter int ROWS      = 60,
    parameter int STROBE_HI = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       busy,
    output logic       bus_cs_n,
    output logic [3:0] bus_rs,
    output logic       bus_wren_n,
    output logic [7:0] bus_data,
    output logic       bus_data_oe,
    output logic       bus_strobe,
    output logic [6:0] cur_x,
    output logic [5:0] cur_y
);
    if ($clog2(COLS) > 7 || $clog2(ROWS) > 6) begin : g_bad_dims
        $error("COLS/ROWS exceed cursor port widths");
    end
    localparam logic [6:0] X_MAX = 7'(COLS - 1);
    localparam logic [5:0] Y_MAX = 6'(ROWS - 1);
    state_e     state_q;
    logic       wait_q, clr_q, sv_q, start, done, need_x, need_y;
    logic [6:0] x_q, shx_q, cx_q, ax;
    logic [5:0] y_q, shy_q, cy_q, ay, y_nxt;
    logic [7:0] ch_q, data;
    logic [3:0] rs;
    // During a clear the cell counters stand in for the cursor as the write address
    assign ax       = clr_q ? cx_q : x_q;
    assign ay       = clr_q ? cy_q : y_q;
    assign need_x   = !sv_q || ax != shx_q;
    assign need_y   = !sv_q || ay != shy_q;
    assign y_nxt    = y_q == Y_MAX ? 6'd0 : y_q + 6'd1;
    assign start    = !wait_q && state_q inside {ST_INIT, ST_SET_X, ST_SET_Y, ST_SET_CH};
    assign in_ready = state_q == ST_IDLE;
    assign busy     = state_q != ST_IDLE;
    assign cur_x    = x_q;
    assign cur_y    = y_q;
    always_comb begin
        rs   = state_q == ST_SET_X ? REG_ADDR_X : state_q == ST_SET_Y ? REG_ADDR_Y :
               state_q == ST_SET_CH ? REG_DATA : REG_MODE;
        data = state_q == ST_SET_X ? {1'b0, ax} : state_q == ST_SET_Y ? {2'b0, ay} :
               state_q == ST_SET_CH ? (clr_q ? CH_SPACE : ch_q) : MODE_MTXT;
    end
    gfx_bus_cycle #(.STROBE_HI(STROBE_HI)) u_bus (
        .clk(clk), .rst(rst), .start_i(start), .rs_i(rs), .data_i(data), .done_o(done),
        .bus_cs_n_o(bus_cs_n), .bus_rs_o(bus_rs), .bus_wren_n_o(bus_wren_n),
        .bus_data_o(bus_data), .bus_data_oe_o(bus_data_oe), .bus_strobe_o(bus_strobe)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            {wait_q, clr_q, sv_q} <= '0;
            {x_q, shx_q, cx_q} <= '0;
            {y_q, shy_q, cy_q} <= '0;
            ch_q <= '0;
        end else begin
            if (start) wait_q <= 1'b1;
            if (done) wait_q <= 1'b0;
            case (state_q)
                ST_INIT: if (done) state_q <= ST_IDLE;
                ST_IDLE: if (in_valid) begin
                    ch_q <= in_data;
                    if (printable(in_data)) state_q <= need_x ? ST_SET_X : need_y ? ST_SET_Y : ST_SET_CH;
                    else if (in_data == CH_FF) begin
                        clr_q   <= 1'b1;
                        cx_q    <= '0;
                        cy_q    <= '0;
                        state_q <= ST_CLEAR;
                    end
                    else if (in_data == CH_CR) x_q <= '0;
                    else if (in_data == CH_LF) y_q <= y_nxt;
                    else if (in_data == CH_BS && x_q != '0) x_q <= x_q - 7'd1;
                end
                ST_CLEAR: state_q <= need_x ? ST_SET_X : need_y ? ST_SET_Y : ST_SET_CH;
                ST_SET_X: if (done) begin
                    shx_q   <= ax;
                    state_q <= need_y ? ST_SET_Y : ST_SET_CH;
                end
                ST_SET_Y: if (done) begin
                    shy_q   <= ay;
                    sv_q    <= 1'b1;
                    state_q <= ST_SET_CH;
                end
                ST_SET_CH: if (done) begin
                    if (clr_q) begin
                        cx_q <= cx_q == X_MAX ? 7'd0 : cx_q + 7'd1;
                        if (cx_q == X_MAX) cy_q <= cy_q == Y_MAX ? 6'd0 : cy_q + 6'd1;
                        if (cx_q == X_MAX && cy_q == Y_MAX) begin
                            clr_q   <= 1'b0;
                            x_q     <= '0;
                            y_q     <= '0;
                            state_q <= ST_IDLE;
                        end else state_q <= ST_CLEAR;
                    end else begin
                        x_q     <= x_q == X_MAX ? 7'd0 : x_q + 7'd1;
                        if (x_q == X_MAX) y_q <= y_nxt;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end
endmodule
